secuenciador_bus_rtc: RTL

//  Sequences the multiplexed address/data bus to the external RTC. Takes a command from the

---
 rtl/secuenciador_bus_rtc_pkg.sv | 63 ++++++
 rtl/secuenciador_bus_rtc_generador_slot.sv | 96 +++++++++
 rtl/secuenciador_bus_rtc.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/secuenciador_bus_rtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : secuenciador_bus_rtc_pkg
//  Description : Shared definitions for the RTC multiplexed-bus sequencer.
//                Contains the command codes, the command port address, the
//                slot phase boundaries, the FSM encoding and a helper that
//                maps a command to the index of its last transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
package secuenciador_bus_rtc_pkg;

    // Command codes written by the picoblaze to the command port
    localparam logic [7:0] C_CMD_IDLE = 8'h00;
    localparam logic [7:0] C_CMD_LECT = 8'h01;
    localparam logic [7:0] C_CMD_ESCR = 8'h02;
    localparam logic [7:0] C_CMD_INIT = 8'h03;

    // port_id that carries commands
    localparam logic [7:0] C_PUERTO   = 8'h10;

    // Phase boundaries inside the 32-cycle bus slot
    localparam logic [4:0] C_FASE_CS_A_INI   = 5'd2;
    localparam logic [4:0] C_FASE_WR_DIR_INI = 5'd4;
    localparam logic [4:0] C_FASE_WR_DIR_FIN = 5'd11;
    localparam logic [4:0] C_FASE_CS_A_FIN   = 5'd13;
    localparam logic [4:0] C_FASE_DIR_FIN    = 5'd15;
    localparam logic [4:0] C_FASE_CS_B_INI   = 5'd18;
    localparam logic [4:0] C_FASE_DATO_INI   = 5'd20;
    localparam logic [4:0] C_FASE_CAPTURA    = 5'd26;
    localparam logic [4:0] C_FASE_DATO_FIN   = 5'd27;
    localparam logic [4:0] C_FASE_CS_B_FIN   = 5'd29;
    localparam logic [4:0] C_FASE_ULTIMA     = 5'd31;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        ST_REPOSO   = 2'd0,
        ST_SINC     = 2'd1,
        ST_TRANSFER = 2'd2,
        ST_FIN      = 2'd3
    } estado_t;

    // Index of the last transfer of the burst selected by a command.
    // Only meaningful for valid burst commands; anything else returns 0.
    function automatic logic [4:0] f_ultimo_indice(
        input logic [7:0] cmd,
        input int         n_lect,
        input int         n_escr,
        input int         n_init
    );
        logic [4:0] v_ultimo;
        v_ultimo = 5'd0;
        case (cmd)
            C_CMD_LECT: v_ultimo = 5'(n_lect - 1);
            C_CMD_ESCR: v_ultimo = 5'(n_escr - 1);
            C_CMD_INIT: v_ultimo = 5'(n_init - 1);
            C_CMD_IDLE: v_ultimo = 5'd0;
            default:    v_ultimo = 5'd0;
        endcase
        return v_ultimo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/secuenciador_bus_rtc_generador_slot.sv
`default_nettype none
// ============================================================================
//  Module      : generador_slot_rtc
//  Description : 32-cycle bus-slot phase counter and RTC strobe decoder.
//                Strobes are registered and decoded from the NEXT counter
//                value, so each strobe is aligned with the cont_32 value it
//                belongs to.
//  Ports       : reloj, resetM      - clock, synchronous active-high reset
//                run                - next cycle is a transfer cycle
//                clr                - force the counter to start at 0
//                es_lectura         - current burst is a read burst
//                cont_32            - slot phase 0..31
//                enable_cont_32     - high while cont_32 == 31 in a transfer
//                CS, RD, WR, AD     - RTC strobes, active-low
//                captura            - read-data sample pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module generador_slot_rtc
    import secuenciador_bus_rtc_pkg::*;
(
    input  logic       reloj,
    input  logic       resetM,
    input  logic       run,
    input  logic       clr,
    input  logic       es_lectura,
    output logic [4:0] cont_32,
    output logic       enable_cont_32,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       AD,
    output logic       captura
);

    logic [4:0] r_cont_q,   w_cont_d;
    logic       r_enable_q, w_enable_d;
    logic       r_cs_q,     w_cs_d;
    logic       r_rd_q,     w_rd_d;
    logic       r_wr_q,     w_wr_d;
    logic       r_ad_q,     w_ad_d;
    logic       r_cap_q,    w_cap_d;

    logic       w_ventana_cs;
    logic       w_ventana_wr_dir;
    logic       w_ventana_dato;

    always_comb begin
        // Counter runs only while transferring; 5-bit wrap gives 31 -> 0
        w_cont_d = 5'd0;
        if (run && !clr) begin
            w_cont_d = r_cont_q + 5'd1;
        end

        w_ventana_cs     = ((w_cont_d >= C_FASE_CS_A_INI) && (w_cont_d <= C_FASE_CS_A_FIN)) ||
                           ((w_cont_d >= C_FASE_CS_B_INI) && (w_cont_d <= C_FASE_CS_B_FIN));
        w_ventana_wr_dir = (w_cont_d >= C_FASE_WR_DIR_INI) && (w_cont_d <= C_FASE_WR_DIR_FIN);
        w_ventana_dato   = (w_cont_d >= C_FASE_DATO_INI) && (w_cont_d <= C_FASE_DATO_FIN);

        w_ad_d     = !(run && (w_cont_d <= C_FASE_DIR_FIN));
        w_cs_d     = !(run && w_ventana_cs);
        w_wr_d     = !(run && (w_ventana_wr_dir || (w_ventana_dato && !es_lectura)));
        w_rd_d     = !(run && w_ventana_dato && es_lectura);
        w_cap_d    = run && es_lectura && (w_cont_d == C_FASE_CAPTURA);
        w_enable_d = run && (w_cont_d == C_FASE_ULTIMA);
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_cont_q   <= 5'd0;
            r_enable_q <= 1'b0;
            r_cs_q     <= 1'b1;
            r_rd_q     <= 1'b1;
            r_wr_q     <= 1'b1;
            r_ad_q     <= 1'b1;
            r_cap_q    <= 1'b0;
        end else begin
            r_cont_q   <= w_cont_d;
            r_enable_q <= w_enable_d;
            r_cs_q     <= w_cs_d;
            r_rd_q     <= w_rd_d;
            r_wr_q     <= w_wr_d;
            r_ad_q     <= w_ad_d;
            r_cap_q    <= w_cap_d;
        end
    end

    assign cont_32        = r_cont_q;
    assign enable_cont_32 = r_enable_q;
    assign CS             = r_cs_q;
    assign RD             = r_rd_q;
    assign WR             = r_wr_q;
    assign AD             = r_ad_q;
    assign captura        = r_cap_q;

endmodule
`default_nettype wire

// File: rtl/secuenciador_bus_rtc.sv
`default_nettype none
// ============================================================================
//  Module      : secuenciador_bus_rtc
//  Description : Sequences the multiplexed address/data bus of the external
//                RTC. Accepts a burst command from the picoblaze, runs one
//                32-cycle slot per transfer and steers the DIR_DATO mux.
//  Ports       : reloj, resetM           - clock, synchronous active-high reset
//                en_01, port_id, out_port - picoblaze write strobe/address/data
//                cont_32, enable_cont_32 - slot phase and end-of-slot flag
//                cont17                  - transfer index within the burst
//                LE                      - read burst (mux releases DIR_DATO)
//                sync                    - command accepted, counters cleared
//                CS, RD, WR, AD          - RTC strobes, active-low
//                captura                 - read-data sample pulse
//                ocupado, fin            - burst in progress / burst complete
//  Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_bus_rtc
    import secuenciador_bus_rtc_pkg::*;
#(
    parameter int         N_LECT = 9,
    parameter int         N_ESCR = 17,
    parameter int         N_INIT = 2,
    parameter logic [7:0] PUERTO = C_PUERTO
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       en_01,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    output logic [4:0] cont_32,
    output logic       enable_cont_32,
    output logic [4:0] cont17,
    output logic       LE,
    output logic       sync,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       AD,
    output logic       captura,
    output logic       ocupado,
    output logic       fin
);

    estado_t    r_estado_q, w_estado_d;
    logic       r_le_q,     w_le_d;
    logic [4:0] r_ultimo_q, w_ultimo_d;
    logic [4:0] r_cont17_q, w_cont17_d;

    logic       w_cmd_valido;
    logic       w_run;
    logic       w_clr;
    logic [4:0] w_cont_32;

    assign w_cmd_valido = en_01 && (port_id == PUERTO) &&
                          ((out_port == C_CMD_LECT) ||
                           (out_port == C_CMD_ESCR) ||
                           (out_port == C_CMD_INIT));

    always_comb begin
        w_estado_d = r_estado_q;
        w_le_d     = r_le_q;
        w_ultimo_d = r_ultimo_q;
        w_cont17_d = r_cont17_q;

        case (r_estado_q)
            ST_REPOSO: begin
                w_cont17_d = 5'd0;
                if (w_cmd_valido) begin
                    w_estado_d = ST_SINC;
                    w_le_d     = (out_port == C_CMD_LECT);
                    w_ultimo_d = f_ultimo_indice(out_port, N_LECT, N_ESCR, N_INIT);
                end
            end
            ST_SINC: begin
                w_cont17_d = 5'd0;
                w_estado_d = ST_TRANSFER;
            end
            ST_TRANSFER: begin
                if (w_cont_32 == C_FASE_ULTIMA) begin
                    if (r_cont17_q == r_ultimo_q) begin
                        w_estado_d = ST_FIN;
                    end else begin
                        w_cont17_d = r_cont17_q + 5'd1;
                    end
                end
            end
            ST_FIN: begin
                // cont17 keeps its final value during FIN and clears on exit
                w_cont17_d = 5'd0;
                w_estado_d = ST_REPOSO;
            end
            default: begin
                w_cont17_d = 5'd0;
                w_estado_d = ST_REPOSO;
            end
        endcase
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_estado_q <= ST_REPOSO;
            r_le_q     <= 1'b0;
            r_ultimo_q <= 5'd0;
            r_cont17_q <= 5'd0;
        end else begin
            r_estado_q <= w_estado_d;
            r_le_q     <= w_le_d;
            r_ultimo_q <= w_ultimo_d;
            r_cont17_q <= w_cont17_d;
        end
    end

    // The slot generator registers its strobes, so it is told what the
    // NEXT cycle will be: run when the FSM is entering/staying in TRANSFER,
    // and clr on the SINC cycle so the first transfer cycle shows phase 0.
    assign w_run = (w_estado_d == ST_TRANSFER);
    assign w_clr = (r_estado_q == ST_SINC);

    generador_slot_rtc u_generador_slot (
        .reloj          (reloj),
        .resetM         (resetM),
        .run            (w_run),
        .clr            (w_clr),
        .es_lectura     (r_le_q),
        .cont_32        (w_cont_32),
        .enable_cont_32 (enable_cont_32),
        .CS             (CS),
        .RD             (RD),
        .WR             (WR),
        .AD             (AD),
        .captura        (captura)
    );

    assign cont_32 = w_cont_32;
    assign cont17  = r_cont17_q;
    assign LE      = r_le_q;
    assign sync    = (r_estado_q == ST_SINC);
    assign ocupado = (r_estado_q == ST_SINC) || (r_estado_q == ST_TRANSFER);
    assign fin     = (r_estado_q == ST_FIN);

endmodule
`default_nettype wire
